// File: rtl/ascii_num_assembler.sv
// ascii_num_assembler: gathers ASCII digits into a packed BCD number.
// A number ends at TERM_CHAR; overflow, an illegal code or an empty number
// raises error. done/error are held until the consumer pulses ack.
// Optional macro ASCII_NUM_BIN_EN adds a running binary value on bin_out.
module ascii_num_assembler #(
  parameter int          N_DIGITS  = 4,
  parameter logic [7:0]  TERM_CHAR = 8'd0,
  parameter int          BIN_W     = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  inicio,
  input  logic [7:0]            Ascii,
  output logic                  ready,
  input  logic                  ack,
  output logic                  done,
  output logic                  error,
  output logic [3:0]            ndig,
  output logic [4*N_DIGITS-1:0] BCD
`ifdef ASCII_NUM_BIN_EN
  ,
  output logic [BIN_W-1:0]      bin_out
`endif
);

  localparam int         BCD_W = 4 * N_DIGITS;
  localparam logic [3:0] MAX_D = 4'(N_DIGITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [BCD_W-1:0] bcd_reg, bcd_next;
  logic [3:0]       ndig_reg, ndig_next;
  logic             ready_reg, done_reg, error_reg;
  logic             is_digit;
  logic [3:0]       digit;

  // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value
  assign is_digit = (Ascii >= 8'd48) && (Ascii <= 8'd57);
  assign digit    = Ascii[3:0];

`ifdef ASCII_NUM_BIN_EN
  logic [BIN_W-1:0] bin_reg, bin_next;
`endif

  // Next-state and next-data logic; init low overrides ack and strobes
  always_comb begin
    state_next = state_reg;
    bcd_next   = bcd_reg;
    ndig_next  = ndig_reg;
`ifdef ASCII_NUM_BIN_EN
    bin_next   = bin_reg;
`endif
    if (!init) begin
      state_next = IDLE;
      bcd_next   = '0;
      ndig_next  = '0;
`ifdef ASCII_NUM_BIN_EN
      bin_next   = '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = COLLECT;
          bcd_next   = '0;
          ndig_next  = '0;
`ifdef ASCII_NUM_BIN_EN
          bin_next   = '0;
`endif
        end
        COLLECT: begin
          if (inicio) begin
            if (is_digit) begin
              if (ndig_reg < MAX_D) begin
                // Top nibble is always zero here, so the shift loses nothing
                bcd_next  = (bcd_reg << 4) | BCD_W'(digit);
                ndig_next = ndig_reg + 4'd1;
`ifdef ASCII_NUM_BIN_EN
                bin_next  = bin_reg * BIN_W'(10) + BIN_W'(digit);
`endif
              end else begin
                state_next = ERR;
              end
            end else if (Ascii == TERM_CHAR) begin
              state_next = (ndig_reg != 4'd0) ? DONE : ERR;
            end else begin
              state_next = ERR;
            end
          end
        end
        DONE, ERR: begin
          if (ack) begin
            state_next = COLLECT;
            bcd_next   = '0;
            ndig_next  = '0;
`ifdef ASCII_NUM_BIN_EN
            bin_next   = '0;
`endif
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, data and registered status flags decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      bcd_reg   <= '0;
      ndig_reg  <= '0;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      bcd_reg   <= bcd_next;
      ndig_reg  <= ndig_next;
      ready_reg <= (state_next == COLLECT);
      done_reg  <= (state_next == DONE);
      error_reg <= (state_next == ERR);
    end
  end

`ifdef ASCII_NUM_BIN_EN
  // Running binary value, cleared and held exactly like the BCD register
  always_ff @(posedge clk) begin
    if (rst) bin_reg <= '0;
    else     bin_reg <= bin_next;
  end
  assign bin_out = bin_reg;
`endif

  assign ready = ready_reg;
  assign done  = done_reg;
  assign error = error_reg;
  assign ndig  = ndig_reg;
  assign BCD   = bcd_reg;

endmodule

// File: tb/tb_ascii_num_assembler.sv
// Directed bench for ascii_num_assembler with a result scoreboard.
module tb_ascii_num_assembler;

  logic        clk = 1'b0;
  logic        rst, init, inicio, ack;
  logic [7:0]  Ascii;
  logic        ready, done, error;
  logic [3:0]  ndig;
  logic [15:0] BCD;
`ifdef ASCII_NUM_BIN_EN
  logic [13:0] bin_out;
`endif

  int total = 0;
  int fails = 0;

  typedef struct {
    logic        err;
    logic [3:0]  nd;
    logic [15:0] bcd;
    logic [13:0] bin;
  } exp_t;
  exp_t sb[$];

  ascii_num_assembler #(.N_DIGITS(4), .TERM_CHAR(8'd0), .BIN_W(14)) dut (
    .clk(clk), .rst(rst), .init(init), .inicio(inicio), .Ascii(Ascii),
    .ready(ready), .ack(ack), .done(done), .error(error), .ndig(ndig),
    .BCD(BCD)
`ifdef ASCII_NUM_BIN_EN
    , .bin_out(bin_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One strobe per cycle; inicio stays high until idle() so strobes can be back-to-back
  task automatic send(input logic [7:0] c);
    inicio = 1'b1;
    Ascii  = c;
    tick();
  endtask

  task automatic idle();
    inicio = 1'b0;
    Ascii  = 8'h20;
  endtask

  task automatic push(input logic err, input logic [3:0] nd, input logic [15:0] bcd, input logic [13:0] bin);
    exp_t e;
    e.err = err; e.nd = nd; e.bcd = bcd; e.bin = bin;
    sb.push_back(e);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    int n = 0;
    while (!(done || error) && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, {31'd0, done | error}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, sb.size(), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_done"},  {31'd0, done},  {31'd0, ~e.err});
      chk({tag, "_error"}, {31'd0, error}, {31'd0, e.err});
      chk({tag, "_ndig"},  {28'd0, ndig},  {28'd0, e.nd});
      chk({tag, "_bcd"},   {16'd0, BCD},   {16'd0, e.bcd});
      chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
`ifdef ASCII_NUM_BIN_EN
      chk({tag, "_bin"},   {18'd0, bin_out}, {18'd0, e.bin});
`endif
    end
    $display("result %s: done=%0b error=%0b ndig=%0d BCD=0x%04h", tag, done, error, ndig, BCD);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, "_ack_done"},  {31'd0, done},  32'd0);
    chk({tag, "_ack_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_ack_ndig"},  {28'd0, ndig},  32'd0);
    chk({tag, "_ack_bcd"},   {16'd0, BCD},   32'd0);
    chk({tag, "_ack_ready"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; inicio = 1'b0; ack = 1'b0; Ascii = 8'h20;
    tick(); tick();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_ndig",  {28'd0, ndig},  32'd0);
    chk("rst_bcd",   {16'd0, BCD},   32'd0);

    rst = 1'b0; init = 1'b1;
    tick();
    chk("start_ready", {31'd0, ready}, 32'd1);

    // "123" + NUL
    send("1");
    chk("d1_ndig", {28'd0, ndig}, 32'd1);
    chk("d1_bcd",  {16'd0, BCD},  32'h1);
    send("2"); send("3");
    push(1'b0, 4'd3, 16'h0123, 14'd123);
    send(8'd0); idle();
    check_result("n123");
    do_ack("n123");

    // overflow on the fifth digit
    send("9"); send("8"); send("7"); send("6");
    push(1'b1, 4'd4, 16'h9876, 14'd9876);
    send("5"); idle();
    check_result("ovf");
    do_ack("ovf");

    // empty number
    push(1'b1, 4'd0, 16'h0, 14'd0);
    send(8'd0); idle();
    check_result("empty");
    do_ack("empty");

    // illegal character after a digit
    send("4");
    push(1'b1, 4'd1, 16'h4, 14'd4);
    send("A"); idle();
    check_result("illegal");
    do_ack("illegal");

    // abort by dropping init; strobe while init low is ignored
    send("5"); send("6"); idle();
    chk("pre_abort_bcd", {16'd0, BCD}, 32'h56);
    init = 1'b0;
    tick();
    chk("abort_ready", {31'd0, ready}, 32'd0);
    chk("abort_ndig",  {28'd0, ndig},  32'd0);
    chk("abort_bcd",   {16'd0, BCD},   32'd0);
    send("9"); idle();
    chk("abort_strobe_ndig", {28'd0, ndig}, 32'd0);
    init = 1'b1;
    tick();
    tick();
    chk("resume_ready", {31'd0, ready}, 32'd1);
    chk("resume_ndig",  {28'd0, ndig},  32'd0);

    // strobe in DONE without ack is ignored
    send("1");
    push(1'b0, 4'd1, 16'h1, 14'd1);
    send(8'd0); idle();
    check_result("one");
    send("7"); idle();
    tick();
    chk("done_hold_done", {31'd0, done}, 32'd1);
    chk("done_hold_bcd",  {16'd0, BCD},  32'h1);
    chk("done_hold_ndig", {28'd0, ndig}, 32'd1);
    do_ack("one");

    // leading zeros are kept
    send("0"); send("0"); send("7");
    push(1'b0, 4'd3, 16'h0007, 14'd7);
    send(8'd0); idle();
    check_result("n007");
    do_ack("n007");

    // reset mid-collection
    send("4"); send("2"); idle();
    chk("pre_rst_ndig", {28'd0, ndig}, 32'd2);
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_ndig",  {28'd0, ndig},  32'd0);
    chk("mid_rst_bcd",   {16'd0, BCD},   32'd0);
    chk("mid_rst_done",  {31'd0, done},  32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_ready", {31'd0, ready}, 32'd1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  // done and error must never be high together
  always @(negedge clk) begin
    if (!rst && done && error) begin
      total++;
      fails++;
      $error("FAIL done_error_both observed=1 expected=0");
    end
  end

endmodule

// File: doc/ascii_num_assembler.md
Name: ascii_num_assembler

Overview:
- Collects a stream of ASCII characters, typically from the UART receive path, into a multi-digit packed BCD number.
- Downstream consumers (7-segment display, setpoint registers) get a whole validated number instead of one digit at a time.
- Replaces single-character conversion: adds digit count, terminator detection, overflow/illegal-character error and a result handshake.

Parameters:
- N_DIGITS, 4, maximum decimal digits held (1..8).
- TERM_CHAR, 8'd0, ASCII code that ends a number (NUL).
- BIN_W, 14, width of binary output (used only with ASCII_NUM_BIN_EN); must hold 10^N_DIGITS-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- init  in  1  session enable; low = abort and hold idle.
- inicio  in  1  character strobe, Ascii valid this cycle.
- Ascii  in  8  input character.
- ready  out  1  block accepts a character this cycle.
- ack  in  1  consumer acknowledges done/error result.
- done  out  1  valid number available on BCD/ndig.
- error  out  1  sequence rejected.
- ndig  out  4  number of digits captured (0..N_DIGITS).
- BCD  out  4*N_DIGITS  packed BCD, least-significant digit in [3:0], unused upper nibbles 0.

Behaviour:
- Interface fixed: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE, ready=0, done=0, error=0, ndig=0, BCD=0 (bin_out=0 if enabled). All outputs registered.
- States: IDLE, COLLECT, DONE, ERR.
- IDLE: ready=0. init=1 -> COLLECT next cycle, with BCD and ndig cleared.
- COLLECT: ready=1. A character is accepted when inicio=1. Strobes in any other state are ignored, with no effect.
- Digit '0'..'9' (48..57) with ndig<N_DIGITS: BCD <= {BCD shifted left 4, Ascii-48}; ndig+1; visible the cycle after the strobe.
- Digit with ndig==N_DIGITS: overflow -> ERR. BCD and ndig hold their last value.
- TERM_CHAR with ndig>=1: -> DONE, done=1 from the next cycle.
- TERM_CHAR with ndig==0: empty number -> ERR.
- Any other code: illegal -> ERR.
- DONE: done=1, ready=0, BCD/ndig stable. ack=1 -> COLLECT next cycle: done=0, BCD=0, ndig=0.
- ERR: error=1, ready=0. ack=1 -> COLLECT next cycle: error=0, BCD=0, ndig=0.
- done and error are never both 1.
- init=0 in any state: -> IDLE next cycle, clearing done, error, BCD and ndig. init has priority over ack and inicio.
- rst has priority over everything.
- Latency: one clock from strobe to updated outputs. Back-to-back strobes on consecutive cycles are supported in COLLECT.
- Leading zeros are kept as digits: "007" gives ndig=3, BCD=0x007.

Optional Feature:
- Macro ASCII_NUM_BIN_EN.
- Defined: adds output port bin_out [BIN_W-1:0]. Each accepted digit updates bin_out <= bin_out*10 + digit in the same cycle BCD updates. bin_out clears wherever BCD clears and is stable in DONE.
- Not defined: port and multiplier logic are absent. All other behaviour is identical.

Test Plan:
- rst; init=1; strobe '1','2','3',NUL on consecutive cycles -> done=1, ndig=3, BCD=0x0123, error=0 (bin_out=123 if enabled); ack -> done=0, BCD=0.
- N_DIGITS=4: strobe '9','8','7','6','5' -> error=1 after 5th strobe; BCD=0x9876, ndig=4; ack -> COLLECT, ready=1.
- Strobe NUL first -> error=1, ndig=0. Strobe 'A' (65) after '4' -> error=1.
- Strobe '5','6' then drop init for one cycle, then raise it -> IDLE, BCD=0, ndig=0, then COLLECT. Strobe during init=0 has no effect.
- In DONE, strobe '7' without ack -> ignored, BCD unchanged. Assert rst mid-collection -> all outputs 0 next cycle.
- Strobe "0","0","7",NUL -> ndig=3, BCD=0x0007, done=1.
